// File: rtl/rr_mux_stage.sv
// rr_mux_stage: NUM_IN-input registered multiplexer with a rotating-priority
// arbiter and valid/ready handshakes on every input and on the output.
//
// Build option: define RR_MUX_FIXED_PRIO_EN to replace the rotating-priority
// arbiter with a fixed-priority one (lowest valid index wins, no ptr register).
//
// Handshake semantics (all ports): an item moves across an interface on a
// rising clk edge where valid and ready are both high in the preceding cycle.
// valid must not wait on ready. Once out_valid is high, out_data and out_src
// hold until the edge that sees out_ready high. in_ready is a combinational
// function of in_valid, out_ready and internal state, so in_valid must not
// depend combinationally on in_ready. At most one in_ready bit is high per
// cycle, and all are forced low while rst_n is low.

module rr_mux_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_IN*WIDTH-1:0]   in_data,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_src
);

    // Unpacked view of the flattened input bus, so the data mux indexes by
    // the grant index directly.
    logic [WIDTH-1:0] chan [NUM_IN];

    // Arbiter results for the current cycle.
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;

    // Output register can take a new item: it is empty or drains this cycle.
    logic can_accept;
    // An input transfer happens on the next edge.
    logic load;

`ifndef RR_MUX_FIXED_PRIO_EN
    // Rotating priority pointer: the channel scanned first.
    logic [SEL_W-1:0] ptr;
`endif

    for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
        assign chan[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign can_accept = !out_valid || out_ready;
    assign load       = grant_valid && can_accept;

    // Arbiter: scan from the priority base with wrap, first valid channel wins.
    always_comb begin
        int base;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
`ifdef RR_MUX_FIXED_PRIO_EN
        base = 0;
`else
        base = int'(ptr);
`endif
        for (int k = 0; k < NUM_IN; k++) begin
            int               idx;
            logic [SEL_W-1:0] sel;
            idx = base + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            sel = SEL_W'(idx);
            if (!grant_valid && in_valid[sel]) begin
                grant_valid = 1'b1;
                grant_idx   = sel;
                grant_data  = chan[sel];
            end
        end
    end

    // Input ready: only the granted channel, only when the register can take
    // it, and never while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (rst_n && load) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register: load on transfer (replacing any item draining in the
    // same cycle), otherwise clear valid on drain; data and src hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_src   <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef RR_MUX_FIXED_PRIO_EN
    // Priority pointer: moves just past the channel granted, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            if (grant_idx == SEL_W'(NUM_IN - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_stage.sv
// tb_rr_mux_stage: directed bench for rr_mux_stage (WIDTH=32, NUM_IN=4).
// Expectations follow the round-robin arbiter by default and the
// fixed-priority arbiter when RR_MUX_FIXED_PRIO_EN is defined.

module tb_rr_mux_stage;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 4;

`ifdef RR_MUX_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic                    clk;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              out_src;

  logic [WIDTH-1:0] din [NUM_IN];

  int n_cmp;
  int n_bad;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_pack
    assign in_data[i*WIDTH +: WIDTH] = din[i];
  end

  rr_mux_stage #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: advance one edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] s);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  out_data, d);
    check({tag, ".src"},   32'(out_src), 32'(s));
  endtask

  initial begin
    int exp_src;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    for (int i = 0; i < NUM_IN; i++) din[i] = 32'hA0 + 32'(i);

    // Reset held with every channel requesting.
    step();
    step();
    check("rst.in_ready", 32'(in_ready), 32'h0);
    check_out("rst", 1'b0, 32'h0, 2'd0);

    // Release: channel 0 granted first.
    rst_n = 1'b1;
    #1;
    check("rel.in_ready", 32'(in_ready), 32'h1);

    // Streaming, all channels valid, out_ready high.
    for (int k = 0; k < 5; k++) begin
      step();
      exp_src = FIXED ? 0 : (k % NUM_IN);
      check_out($sformatf("stream%0d", k), 1'b1, 32'hA0 + 32'(exp_src), 2'(exp_src));
      check($sformatf("stream%0d.in_ready", k), 32'(in_ready),
            FIXED ? 32'h1 : (32'h1 << ((k + 1) % NUM_IN)));
    end

    // Idle drain: valid falls, data and src hold.
    in_valid = 4'h0;
    #1;
    check("idle.in_ready", 32'(in_ready), 32'h0);
    step();
    check_out("idle", 1'b0, 32'hA0, 2'd0);

    // Backpressure: hold 0x11 while channel 2 waits.
    din[1]   = 32'h11;
    din[2]   = 32'h22;
    in_valid = 4'b0010;
    step();
    check_out("bp.load", 1'b1, 32'h11, 2'd1);
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'h0);
      check_out($sformatf("bp%0d", k), 1'b1, 32'h11, 2'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release.in_ready", 32'(in_ready), 32'h4);
    step();
    in_valid = 4'b0011;
    check_out("bp.swap", 1'b1, 32'h22, 2'd2);

    // Wrap and skip: ptr=3, channels 0 and 1 valid.
    din[0] = 32'h30;
    din[1] = 32'h31;
    #1;
    check("wrap.in_ready0", 32'(in_ready), 32'h1);
    step();
    check_out("wrap.g0", 1'b1, 32'h30, 2'd0);
    check("wrap.in_ready1", 32'(in_ready), FIXED ? 32'h1 : 32'h2);
    step();
    check_out("wrap.g1", 1'b1, FIXED ? 32'h30 : 32'h31, FIXED ? 2'd0 : 2'd1);

    // Mid-operation reset while an item is held under backpressure.
    in_valid  = 4'h0;
    out_ready = 1'b0;
    step();
    check("hold.valid", 32'(out_valid), 32'h1);
    #3;
    in_valid = 4'hF;
    rst_n    = 1'b0;
    #1;
    check_out("midrst", 1'b0, 32'h0, 2'd0);
    check("midrst.in_ready", 32'(in_ready), 32'h0);
    step();
    rst_n     = 1'b1;
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    #1;
    check("postrst.in_ready", 32'(in_ready), 32'h2);
    step();
    check_out("postrst", 1'b1, 32'h31, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
